// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Microcode sequencer between the ID stage and the micro-op
//             memory. Dispatches decoded instructions from the wait address,
//             walks micro-routines using per-word sequencing bits, counts
//             retired routines and latches illegal/timeout faults.
//  Revision : 1.0  initial release
// ============================================================================
module micro_sequencer #(
  parameter int UADDR_W   = 5,
  parameter int UWORD_W   = 16,
  parameter int WAIT_ADDR = 18,
  parameter int MAX_STEPS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid_inst,
  input  logic                         id_illegal,
  input  logic [UADDR_W-1:0]           id_decode_addr,
  output logic                         id_ready,
  input  logic [UWORD_W-1:0]           uword_in,
  output logic [UADDR_W-1:0]           uaddr_out,
  output logic                         uop_valid,
  output logic [UWORD_W-UADDR_W-3:0]   uop_ctrl,
  input  logic                         cond_in,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         busy,
  output logic                         halted,
  output logic [1:0]                   halt_cause,
  output logic [31:0]                  retired_cnt
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [UADDR_W-1:0] c_WAIT      = UADDR_W'(WAIT_ADDR);
  localparam logic [STEP_W-1:0]  c_LAST_STEP = STEP_W'(MAX_STEPS - 1);

  localparam logic [1:0] c_SEQ_NEXT = 2'b00;
  localparam logic [1:0] c_SEQ_JUMP = 2'b01;
  localparam logic [1:0] c_SEQ_END  = 2'b10;
  localparam logic [1:0] c_SEQ_COND = 2'b11;

  localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [UADDR_W-1:0]  r_uaddr,   w_uaddr_nxt;
  logic [STEP_W-1:0]   r_step,    w_step_nxt;
  logic [31:0]         r_retired, w_retired_nxt;
  logic [1:0]          r_cause,   w_cause_nxt;

  logic [1:0]          w_seq;
  logic [UADDR_W-1:0]  w_target;
  logic [UADDR_W-1:0]  w_incr;
  logic                w_accept;

  assign w_seq    = uword_in[1:0];
  assign w_target = uword_in[UADDR_W+1:2];
  assign w_incr   = r_uaddr + 1'b1;

  assign id_ready    = (r_state == S_IDLE) & ~stall & ~flush;
  assign w_accept    = id_valid_inst & id_ready;
  assign uop_valid   = (r_state == S_RUN) & ~stall & ~flush;
  assign uop_ctrl    = uword_in[UWORD_W-1:UADDR_W+2];
  assign uaddr_out   = r_uaddr;
  assign busy        = (r_state == S_RUN);
  assign halted      = (r_state == S_HALT);
  assign halt_cause  = r_cause;
  assign retired_cnt = r_retired;

  // State register plus address, step, retire and fault-cause registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_uaddr   <= c_WAIT;
      r_step    <= '0;
      r_retired <= '0;
      r_cause   <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_uaddr   <= w_uaddr_nxt;
      r_step    <= w_step_nxt;
      r_retired <= w_retired_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  // Next-state logic: dispatch, micro-word sequencing, flush and faults
  always_comb begin
    w_state_nxt   = r_state;
    w_uaddr_nxt   = r_uaddr;
    w_step_nxt    = r_step;
    w_retired_nxt = r_retired;
    w_cause_nxt   = r_cause;

    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_uaddr_nxt = c_WAIT;
          w_step_nxt  = '0;
        end else if (w_accept) begin
          if (id_illegal) begin
            w_state_nxt = S_HALT;
            w_cause_nxt = c_CAUSE_ILLEGAL;
          end else if (id_decode_addr == c_WAIT) begin
            // Entry at the wait address is a routine of zero length
            w_retired_nxt = r_retired + 32'd1;
          end else begin
            w_uaddr_nxt = id_decode_addr;
            w_step_nxt  = '0;
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_uaddr_nxt = c_WAIT;
          w_step_nxt  = '0;
        end else if (!stall) begin
          w_step_nxt = r_step + 1'b1;
          case (w_seq)
            c_SEQ_NEXT: w_uaddr_nxt = w_incr;
            c_SEQ_JUMP: w_uaddr_nxt = w_target;
            c_SEQ_COND: w_uaddr_nxt = cond_in ? w_target : w_incr;
            default: begin
              w_uaddr_nxt   = c_WAIT;
              w_step_nxt    = '0;
              w_state_nxt   = S_IDLE;
              w_retired_nxt = r_retired + 32'd1;
            end
          endcase
          // Last permitted step that does not finish the routine is a runaway
          if ((w_seq != c_SEQ_END) && (r_step == c_LAST_STEP)) begin
            w_state_nxt = S_HALT;
            w_cause_nxt = c_CAUSE_TIMEOUT;
            w_uaddr_nxt = c_WAIT;
          end
        end
      end

      S_HALT: begin
        w_uaddr_nxt = c_WAIT;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_uaddr_nxt = c_WAIT;
        w_step_nxt  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Self-checking bench for micro_sequencer with a behavioural
//             model of the dispatch/sequencing rules and a micro-op memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_micro_sequencer;

  localparam int UADDR_W   = 5;
  localparam int UWORD_W   = 16;
  localparam int WAIT_ADDR = 18;
  localparam int MAX_STEPS = 16;
  localparam int CTRL_W    = UWORD_W - UADDR_W - 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 id_valid_inst = 1'b0;
  logic                 id_illegal = 1'b0;
  logic [UADDR_W-1:0]   id_decode_addr = '0;
  logic                 id_ready;
  logic [UWORD_W-1:0]   uword_in;
  logic [UADDR_W-1:0]   uaddr_out;
  logic                 uop_valid;
  logic [CTRL_W-1:0]    uop_ctrl;
  logic                 cond_in = 1'b0;
  logic                 stall = 1'b0;
  logic                 flush = 1'b0;
  logic                 busy;
  logic                 halted;
  logic [1:0]           halt_cause;
  logic [31:0]          retired_cnt;

  logic [UWORD_W-1:0]   mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy;
  bit          m_halted;
  int          m_addr;
  int          m_steps;
  logic [31:0] m_ret;
  int          m_cause;

  always #5 clk = ~clk;

  assign uword_in = mem[uaddr_out];

  micro_sequencer #(
    .UADDR_W(UADDR_W), .UWORD_W(UWORD_W), .WAIT_ADDR(WAIT_ADDR), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_inst(id_valid_inst), .id_illegal(id_illegal), .id_decode_addr(id_decode_addr),
    .id_ready(id_ready), .uword_in(uword_in), .uaddr_out(uaddr_out),
    .uop_valid(uop_valid), .uop_ctrl(uop_ctrl), .cond_in(cond_in),
    .stall(stall), .flush(flush), .busy(busy), .halted(halted),
    .halt_cause(halt_cause), .retired_cnt(retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [UWORD_W-1:0] mk(input int ctrl, input int tgt, input int seq);
    logic [UWORD_W-1:0] w;
    w = UWORD_W'((ctrl % 512) * 128 + (tgt % 32) * 4 + (seq % 4));
    return w;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_halted = 0; m_addr = WAIT_ADDR; m_steps = 0; m_ret = 0; m_cause = 0;
  endtask

  // Apply one clock of the sequencing rules using the inputs currently driven
  task automatic model_step();
    int w, seq, tgt, nxt;
    if (m_halted) return;
    if (flush) begin
      m_busy = 0; m_addr = WAIT_ADDR; m_steps = 0;
      return;
    end
    if (stall) return;
    if (!m_busy) begin
      if (id_valid_inst) begin
        if (id_illegal) begin
          m_halted = 1; m_cause = 1;
        end else if (int'(id_decode_addr) == WAIT_ADDR) begin
          m_ret = m_ret + 1;
        end else begin
          m_busy = 1; m_addr = int'(id_decode_addr); m_steps = 0;
        end
      end
      return;
    end
    w   = int'(mem[m_addr]);
    seq = w % 4;
    tgt = (w / 4) % 32;
    if (seq == 2) begin
      m_busy = 0; m_addr = WAIT_ADDR; m_steps = 0; m_ret = m_ret + 1;
      return;
    end
    if (seq == 0)      nxt = (m_addr + 1) % 32;
    else if (seq == 1) nxt = tgt;
    else               nxt = cond_in ? tgt : (m_addr + 1) % 32;
    m_steps = m_steps + 1;
    if (m_steps >= MAX_STEPS) begin
      m_busy = 0; m_halted = 1; m_cause = 2; m_addr = WAIT_ADDR;
    end else begin
      m_addr = nxt;
    end
  endtask

  task automatic check_all();
    logic [UWORD_W-1:0] w;
    bit exp_ready, exp_valid;
    w = mem[m_addr];
    exp_ready = !m_busy && !m_halted && !stall && !flush;
    exp_valid = m_busy && !stall && !flush;
    chk("uaddr",     32'(uaddr_out),   32'(m_addr));
    chk("busy",      32'(busy),        32'(m_busy));
    chk("halted",    32'(halted),      32'(m_halted));
    chk("cause",     32'(halt_cause),  32'(m_cause));
    chk("retired",   retired_cnt,      m_ret);
    chk("id_ready",  32'(id_ready),    32'(exp_ready));
    chk("uop_valid", 32'(uop_valid),   32'(exp_valid));
    chk("uop_ctrl",  32'(uop_ctrl),    32'(w[UWORD_W-1:UADDR_W+2]));
  endtask

  // One clock: drive at negedge, check, then advance the model on posedge
  task automatic cyc(input bit v, input bit il, input int a, input bit c, input bit s, input bit f);
    @(negedge clk);
    id_valid_inst  = v;
    id_illegal     = il;
    id_decode_addr = UADDR_W'(a);
    cond_in        = c;
    stall          = s;
    flush          = f;
    #1;
    check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_end();
    for (int i = 0; i < 32; i++) mem[i] = mk($urandom, 0, 2);
  endtask

  // Async reset asserted mid-cycle; outputs must take reset values at once
  task automatic reset_dut();
    @(negedge clk);
    id_valid_inst = 0; id_illegal = 0; id_decode_addr = '0;
    cond_in = 0; stall = 0; flush = 0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    fill_end();
    model_reset();
    reset_dut();

    // Single routine: NEXT at 4, END at 5
    mem[4] = mk(9'h1A5, 0, 0);
    mem[5] = mk(9'h0F0, 0, 2);
    cyc(1, 0, 4, 0, 0, 0);  #2; chk("single_addr4", 32'(uaddr_out), 4);
    idle();                 #2; chk("single_addr5", 32'(uaddr_out), 5);
    idle();                 #2; chk("single_addr18", 32'(uaddr_out), 18);
    chk("single_ret", retired_cnt, 1);
    chk("single_ready", 32'(id_ready), 1);
    idle();

    // Conditional branch taken and not taken
    reset_dut();
    fill_end();
    mem[21] = mk(9'h033, 26, 3);
    cyc(1, 0, 21, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);  #2; chk("cond_taken", 32'(uaddr_out), 26);
    idle();
    cyc(1, 0, 21, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);  #2; chk("cond_fall", 32'(uaddr_out), 22);
    idle();

    // Stall holds the routine, flush with stall aborts it
    reset_dut();
    fill_end();
    mem[8] = mk(9'h055, 0, 0);
    cyc(1, 0, 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0); #2; chk("stall_hold", 32'(uaddr_out), 8);
    end
    cyc(0, 0, 0, 0, 1, 1);  #2; chk("flush_addr", 32'(uaddr_out), 18);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_ret", retired_cnt, 0);
    idle();

    // Illegal instruction halts and stays halted
    reset_dut();
    cyc(1, 1, 4, 0, 0, 0);  #2; chk("ill_halted", 32'(halted), 1);
    chk("ill_cause", 32'(halt_cause), 1);
    chk("ill_ready", 32'(id_ready), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 4, 0, i[0], i[1]);
    #2; chk("ill_sticky", 32'(halted), 1);

    // Timeout after MAX_STEPS non-END steps
    reset_dut();
    for (int i = 0; i < 16; i++) mem[i] = mk($urandom, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAX_STEPS - 1; i++) idle();
    #2; chk("to_not_yet", 32'(halted), 0);
    chk("to_addr15", 32'(uaddr_out), 15);
    idle();
    #2; chk("to_halted", 32'(halted), 1);
    chk("to_cause", 32'(halt_cause), 2);
    chk("to_addr", 32'(uaddr_out), 18);

    // Address wrap: JUMP to 31 then NEXT
    reset_dut();
    fill_end();
    mem[10] = mk(9'h0AA, 31, 1);
    mem[31] = mk(9'h155, 0, 0);
    cyc(1, 0, 10, 0, 0, 0);
    idle();                 #2; chk("wrap_31", 32'(uaddr_out), 31);
    idle();                 #2; chk("wrap_0", 32'(uaddr_out), 0);
    idle();

    // Wait-address no-op
    reset_dut();
    cyc(1, 0, WAIT_ADDR, 0, 0, 0); #2; chk("noop_ret", retired_cnt, 1);
    chk("noop_busy", 32'(busy), 0);
    idle();

    // Randomized traffic with occasional async resets
    reset_dut();
    for (int i = 0; i < 32; i++) mem[i] = UWORD_W'($urandom);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_dut();
        for (int i = 0; i < 32; i++) mem[i] = UWORD_W'($urandom);
      end else begin
        cyc($urandom_range(0, 2) != 0,
            $urandom_range(0, 59) == 0,
            ($urandom_range(0, 7) == 0) ? WAIT_ADDR : int'($urandom_range(0, 31)),
            1'($urandom),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 14) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
